core_mul_iter: RTL and testbench
================================

Name: core_mul_iter

Overview:
- Iterative RV64M/RV32M integer multiplier for the core's execute-stage M-extension path.
- Covers MUL, MULH, MULHSU, MULHU and MULW.
- Conditions operands to magnitudes, runs a radix-2^BPC shift-add loop, applies sign correction, then selects and extends the result.
- Valid/ready handshake on both sides. Accepts one operation at a time; supports pipeline flush.

Parameters:
- XLEN, 64, datapath width; must be even; XLEN/2 is the word width.
- BPC, 1, multiplier bits retired per CALC cycle; must divide XLEN/2 (1, 2, 4, 8 legal).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_mul_valid  in  1  request valid.
- o_mul_ready  out  1  block can accept; high only in IDLE.
- i_mul_srcA  in  XLEN  operand rs1.
- i_mul_srcB  in  XLEN  operand rs2.
- i_mul_control  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- i_mul_isword  in  1  word op (MULW); control is ignored when set.
- i_mul_flush  in  1  synchronous abort of the in-flight operation.
- o_mul_valid  out  1  result valid.
- i_mul_out_ready  in  1  consumer accepts the result.
- o_mul_result  out  XLEN  final result.
- o_mul_busy  out  1  high in CALC, FIN, DONE.

Behaviour:
- Reset (asynchronous, i_rst_n low):
  - state=IDLE.
  - o_mul_valid=0, o_mul_result=0, o_mul_busy=0, o_mul_ready=1 after release.
  - All internal registers cleared.
- States: IDLE -> CALC -> FIN -> DONE -> IDLE.
- IDLE, on i_mul_valid & o_mul_ready (accept edge):
  - Latch magnitude multiplicand into 2*XLEN register (zero-extended).
  - Latch magnitude multiplier into XLEN register.
  - Latch negate flag, op and isword. Clear accumulator. Load iteration counter ITER.
- Operand signedness:
  - MUL/MULH: A and B signed.
  - MULHSU: A signed, B unsigned.
  - MULHU: both unsigned.
  - MULW: low XLEN/2 bits, both signed; upper input bits ignored.
- Conditioning:
  - Magnitude = two's-complement negation when the operand is treated as signed and its sign bit is set.
  - The most-negative value maps to 2^(n-1) unsigned; no overflow.
- Negate flag = signA_eff XOR signB_eff.
- ITER = XLEN/BPC, or (XLEN/2)/BPC for word ops.
- CALC, each edge:
  - acc += multiplicand * mplier[BPC-1:0].
  - multiplicand <<= BPC; mplier >>= BPC; counter--.
  - Counter reaching 0 -> FIN.
- FIN:
  - prod = negate ? -acc : acc (2*XLEN wide). Negating a zero product gives 0.
  - Result register:
    - MUL: prod[XLEN-1:0].
    - MULH/MULHSU/MULHU: prod[2*XLEN-1:XLEN].
    - MULW: sign-extend prod[XLEN/2-1:0] from bit XLEN/2-1.
  - Next state DONE.
- DONE:
  - o_mul_valid=1. Result held stable until i_mul_out_ready.
  - Handshake edge -> IDLE, o_mul_valid=0 on that edge.
- Latency: o_mul_valid rises ITER+1 edges after the accept edge. XLEN=64 gives:
  - BPC=1: 65 (MUL), 33 (MULW).
  - BPC=4: 17 (MUL), 9 (MULW).
- Flush:
  - i_mul_flush in CALC/FIN/DONE -> IDLE next edge; o_mul_valid deasserts, no result is delivered.
  - Flush in IDLE blocks an acceptance in that same cycle.
  - Flush has priority over all other events.
- Inputs are ignored outside IDLE. Operands need not be held after acceptance.
- Asynchronous reset mid-operation -> IDLE immediately; the operation is discarded.

Optional Feature:
- Macro: MUL_EARLY_OUT_EN.
- Defined:
  - In CALC, if the remaining mplier register == 0, go to FIN at the next edge regardless of the counter.
  - Correct because the multiplicand is shifted left each cycle.
  - Latency = (number of BPC-digits up to the multiplier's MSB set bit) + 1; minimum 2 for a zero multiplier (one CALC, one FIN).
- Undefined: fixed latency ITER+1 always.

Decomposition:
- Package core_mul_pkg:
  - mul_op_e enum (MUL, MULH, MULHSU, MULHU).
  - mul_state_e enum (IDLE, CALC, FIN, DONE).
  - Function mul_iters(xlen, bpc, isword).
- Sub-module core_mul_operand_cond (combinational):
  - Inputs: srcA, srcB, control, isword.
  - Outputs: magnitudes and negate flag.
  - Instantiated once; the FSM and datapath live in core_mul_iter.

Test Plan (XLEN=64, BPC=1 unless stated):
- MUL, A=0xFFFF_FFFF_FFFF_FFFD (-3), B=7 -> result 0xFFFF_FFFF_FFFF_FFEB; o_mul_valid first high exactly 65 edges after accept.
- MULH, A=B=0x8000_0000_0000_0000 -> 0x4000_0000_0000_0000.
- MULHU, A=B=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE.
- MULHSU, A=0xFFFF_FFFF_FFFF_FFFF, B=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFF.
- MULW, A=0x0000_0001_0000_0002, B=0x0000_0000_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE in 33 edges; with BPC=4 -> 9 edges, same value.
- Backpressure and flush:
  - Hold i_mul_out_ready low 5 cycles in DONE -> o_mul_valid and o_mul_result stable, o_mul_ready=0.
  - Flush 10 edges into CALC -> IDLE next edge, no valid.
  - Immediate new MUL 6*7 -> 42.
- Reset and early-out:
  - Drop i_rst_n at CALC edge 20 -> all outputs at reset values asynchronously, o_mul_ready=1 after release.
  - With MUL_EARLY_OUT_EN: MULHU A=5, B=3 -> result 0, valid 3 edges after accept.
  - Without MUL_EARLY_OUT_EN: 65 edges.

Source files
------------

// File: rtl/core_mul_pkg.sv
// Shared types and helpers for the iterative RV64M/RV32M multiplier.
package core_mul_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIN,
    ST_DONE
  } mul_state_e;

  // Number of CALC cycles needed to retire every multiplier digit.
  function automatic int mul_iters(input int xlen, input int bpc, input logic isword);
    return isword ? (xlen / 2) / bpc : xlen / bpc;
  endfunction

endpackage

// File: rtl/core_mul_operand_cond.sv
// Combinational operand conditioning: per-op signedness, magnitudes and product sign.
module core_mul_operand_cond
  import core_mul_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] i_src_a,
  input  logic [XLEN-1:0] i_src_b,
  input  logic [1:0]      i_control,
  input  logic            i_isword,
  output logic [XLEN-1:0] o_mag_a,
  output logic [XLEN-1:0] o_mag_b,
  output logic            o_negate
);

  localparam int HALF = XLEN / 2;

  mul_op_e         op;
  logic            signed_a;
  logic            signed_b;
  logic            neg_a;
  logic            neg_b;
  logic [XLEN-1:0] ext_a;
  logic [XLEN-1:0] ext_b;

  always_comb begin
    op       = mul_op_e'(i_control);
    signed_a = i_isword | (op != OP_MULHU);
    signed_b = i_isword | (op == OP_MUL) | (op == OP_MULH);
    // Word ops look only at the low half; sign-extending first lets one
    // negation path serve both widths (2^(HALF-1) still fits unsigned).
    ext_a    = i_isword ? {{HALF{i_src_a[HALF-1]}}, i_src_a[HALF-1:0]} : i_src_a;
    ext_b    = i_isword ? {{HALF{i_src_b[HALF-1]}}, i_src_b[HALF-1:0]} : i_src_b;
    neg_a    = signed_a & ext_a[XLEN-1];
    neg_b    = signed_b & ext_b[XLEN-1];
    o_mag_a  = neg_a ? (~ext_a + 1'b1) : ext_a;
    o_mag_b  = neg_b ? (~ext_b + 1'b1) : ext_b;
    o_negate = neg_a ^ neg_b;
  end

endmodule

// File: rtl/core_mul_iter.sv
// Iterative radix-2^BPC shift-add multiplier (MUL/MULH/MULHSU/MULHU/MULW).
// Optional MUL_EARLY_OUT_EN: leave CALC as soon as the remaining multiplier is zero.
module core_mul_iter
  import core_mul_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int BPC  = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_mul_valid,
  output logic            o_mul_ready,
  input  logic [XLEN-1:0] i_mul_srcA,
  input  logic [XLEN-1:0] i_mul_srcB,
  input  logic [1:0]      i_mul_control,
  input  logic            i_mul_isword,
  input  logic            i_mul_flush,
  output logic            o_mul_valid,
  input  logic            i_mul_out_ready,
  output logic [XLEN-1:0] o_mul_result,
  output logic            o_mul_busy
);

  localparam int W2   = 2 * XLEN;
  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN / BPC + 1);

  mul_state_e      state_q,  state_d;
  logic [W2-1:0]   mcand_q,  mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [W2-1:0]   acc_q,    acc_d;
  logic [CW-1:0]   cnt_q,    cnt_d;
  logic            neg_q,    neg_d;
  mul_op_e         op_q,     op_d;
  logic            isword_q, isword_d;
  logic [XLEN-1:0] result_q, result_d;

  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            negate;
  logic [W2-1:0]   step_sum;
  logic [W2-1:0]   prod;
  logic [W2-1:0]   pp [BPC];

  core_mul_operand_cond #(.XLEN(XLEN)) u_cond (
    .i_src_a   (i_mul_srcA),
    .i_src_b   (i_mul_srcB),
    .i_control (i_mul_control),
    .i_isword  (i_mul_isword),
    .o_mag_a   (mag_a),
    .o_mag_b   (mag_b),
    .o_negate  (negate)
  );

  // One shifted copy of the multiplicand per bit of the current digit.
  for (genvar gi = 0; gi < BPC; gi++) begin : g_pp
    assign pp[gi] = mplier_q[gi] ? (mcand_q << gi) : '0;
  end

  always_comb begin
    step_sum = '0;
    for (int i = 0; i < BPC; i++) begin
      step_sum = step_sum + pp[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    op_d     = op_q;
    isword_d = isword_q;
    result_d = result_q;
    prod     = neg_q ? (~acc_q + 1'b1) : acc_q;

    case (state_q)
      ST_IDLE: begin
        if (i_mul_valid && !i_mul_flush) begin
          state_d  = ST_CALC;
          mcand_d  = {{XLEN{1'b0}}, mag_a};
          mplier_d = mag_b;
          neg_d    = negate;
          op_d     = mul_op_e'(i_mul_control);
          isword_d = i_mul_isword;
          acc_d    = '0;
          cnt_d    = CW'(mul_iters(XLEN, BPC, i_mul_isword));
        end
      end
      ST_CALC: begin
        acc_d    = acc_q + step_sum;
        mcand_d  = mcand_q << BPC;
        mplier_d = mplier_q >> BPC;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = ST_FIN;
        end
`ifdef MUL_EARLY_OUT_EN
        if (mplier_d == '0) begin
          state_d = ST_FIN;
        end
`endif
      end
      ST_FIN: begin
        if (isword_q) begin
          result_d = {{HALF{prod[HALF-1]}}, prod[HALF-1:0]};
        end else if (op_q == OP_MUL) begin
          result_d = prod[XLEN-1:0];
        end else begin
          result_d = prod[W2-1:XLEN];
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (i_mul_out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over every other transition.
    if (i_mul_flush && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      op_q     <= OP_MUL;
      isword_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      op_q     <= op_d;
      isword_q <= isword_d;
      result_q <= result_d;
    end
  end

  assign o_mul_ready  = (state_q == ST_IDLE);
  assign o_mul_valid  = (state_q == ST_DONE);
  assign o_mul_busy   = (state_q != ST_IDLE);
  assign o_mul_result = result_q;

endmodule

// File: tb/tb_core_mul_iter.sv
// Directed plus randomized checks of core_mul_iter against a 128-bit arithmetic reference.
module tb_core_mul_iter;

  logic        clk;
  logic        rst_n;
  logic        mul_valid;
  logic        mul_ready;
  logic [63:0] src_a;
  logic [63:0] src_b;
  logic [1:0]  control;
  logic        isword;
  logic        flush;
  logic        res_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  core_mul_iter #(.XLEN(64), .BPC(1)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_mul_valid     (mul_valid),
    .o_mul_ready     (mul_ready),
    .i_mul_srcA      (src_a),
    .i_mul_srcB      (src_b),
    .i_mul_control   (control),
    .i_mul_isword    (isword),
    .i_mul_flush     (flush),
    .o_mul_valid     (res_valid),
    .i_mul_out_ready (out_ready),
    .o_mul_result    (result),
    .o_mul_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference product: extend both operands to 128 bits per the op's signedness and multiply.
  function automatic logic [63:0] ref_result(input logic [63:0] a, input logic [63:0] b,
                                             input logic [1:0] ctl, input logic w);
    logic [127:0] ea, eb, p;
    logic [31:0]  lo;
    if (w) begin
      ea = {{96{a[31]}}, a[31:0]};
      eb = {{96{b[31]}}, b[31:0]};
      p  = ea * eb;
      lo = p[31:0];
      return {{32{lo[31]}}, lo};
    end
    ea = (ctl == 2'b11) ? {64'd0, a} : {{64{a[63]}}, a};
    eb = (ctl == 2'b00 || ctl == 2'b01) ? {{64{b[63]}}, b} : {64'd0, b};
    p  = ea * eb;
    return (ctl == 2'b00) ? p[63:0] : p[127:64];
  endfunction

  function automatic int ref_latency(input logic [63:0] b, input logic [1:0] ctl, input logic w);
`ifdef MUL_EARLY_OUT_EN
    logic [63:0] mag;
    int          n;
    if (w) mag = b[31] ? (64'd0 - {{32{b[31]}}, b[31:0]}) : {32'd0, b[31:0]};
    else if ((ctl == 2'b00 || ctl == 2'b01) && b[63]) mag = 64'd0 - b;
    else mag = b;
    n = 1;
    for (int i = 0; i < 64; i++) if (mag[i]) n = i + 1;
    return n + 1;
`else
    return w ? 33 : 65;
`endif
  endfunction

  // Issue one operation, measure latency, optionally stall the consumer, then retire it.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [1:0] ctl,
                        input logic w, input int stall, input string tag,
                        output logic [63:0] res, output int lat);
    logic [63:0] exp_res;
    int          exp_lat;
    exp_res = ref_result(a, b, ctl, w);
    exp_lat = ref_latency(b, ctl, w);
    @(negedge clk);
    check({tag, "_ready_before"}, 64'(mul_ready), 64'd1);
    mul_valid = 1'b1; src_a = a; src_b = b; control = ctl; isword = w; out_ready = 1'b0;
    @(posedge clk); #1;
    mul_valid = 1'b0; src_a = {$urandom, $urandom}; src_b = {$urandom, $urandom};
    control = 2'($urandom); isword = 1'($urandom);
    lat = 0;
    while (!res_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_valid_seen"}, 64'(res_valid), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_result"}, result, exp_res);
    res = result;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check({tag, "_stall_valid"}, 64'(res_valid), 64'd1);
      check({tag, "_stall_result"}, result, exp_res);
      check({tag, "_stall_ready"}, 64'(mul_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(res_valid), 64'd0);
    check({tag, "_ready_after"}, 64'(mul_ready), 64'd1);
    $display("op %s a=%h b=%h ctl=%0d w=%0d result=%h latency=%0d", tag, a, b, ctl, w, res, lat);
  endtask

  initial begin
    logic [63:0] r;
    logic [63:0] a, b;
    logic [1:0]  ctl;
    logic        w;
    int          lat;
    int          edges;

    rst_n = 1'b0; mul_valid = 1'b0; src_a = '0; src_b = '0; control = '0;
    isword = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_valid", 64'(res_valid), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", 64'(mul_ready), 64'd1);

    run_op(64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 2'b00, 1'b0, 0, "mul_neg", r, lat);
    check("mul_neg_const", r, 64'hFFFF_FFFF_FFFF_FFEB);
`ifndef MUL_EARLY_OUT_EN
    check("mul_neg_lat65", 64'(lat), 64'd65);
`endif
    run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b01, 1'b0, 0, "mulh", r, lat);
    check("mulh_const", r, 64'h4000_0000_0000_0000);
    run_op('1, '1, 2'b11, 1'b0, 0, "mulhu", r, lat);
    check("mulhu_const", r, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op('1, '1, 2'b10, 1'b0, 0, "mulhsu", r, lat);
    check("mulhsu_const", r, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(64'h0000_0001_0000_0002, 64'h0000_0000_FFFF_FFFF, 2'b11, 1'b1, 0, "mulw", r, lat);
    check("mulw_const", r, 64'hFFFF_FFFF_FFFF_FFFE);
`ifndef MUL_EARLY_OUT_EN
    check("mulw_lat33", 64'(lat), 64'd33);
`endif
    run_op(64'd5, 64'd3, 2'b11, 1'b0, 0, "mulhu_small", r, lat);
    check("mulhu_small_const", r, 64'd0);
`ifdef MUL_EARLY_OUT_EN
    check("early_lat3", 64'(lat), 64'd3);
`else
    check("fixed_lat65", 64'(lat), 64'd65);
`endif

    // Backpressure: consumer holds off for 5 cycles.
    run_op(64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0001, 2'b00, 1'b0, 5, "bp", r, lat);

    // Flush 10 edges into CALC.
    @(negedge clk);
    mul_valid = 1'b1; src_a = 64'd99; src_b = 64'hFFFF_FFFF_FFFF_FFFF; control = 2'b00; isword = 1'b0;
    @(posedge clk); #1;
    mul_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_ready", 64'(mul_ready), 64'd1);
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_valid", 64'(res_valid), 64'd0);
    edges = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (res_valid) edges++;
    end
    check("flush_no_result", 64'(edges), 64'd0);
    run_op(64'd6, 64'd7, 2'b00, 1'b0, 0, "after_flush", r, lat);
    check("after_flush_const", r, 64'd42);

    // Flush in IDLE suppresses acceptance.
    @(negedge clk);
    mul_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    mul_valid = 1'b0; flush = 1'b0;
    check("idle_flush_busy", 64'(busy), 64'd0);
    check("idle_flush_ready", 64'(mul_ready), 64'd1);

    // Asynchronous reset 20 edges into CALC.
    @(negedge clk);
    mul_valid = 1'b1; src_a = 64'd12345; src_b = '1; control = 2'b00; isword = 1'b0;
    @(posedge clk); #1;
    mul_valid = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_valid", 64'(res_valid), 64'd0);
    check("async_rst_result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_release_ready", 64'(mul_ready), 64'd1);

    // Randomized operations against the reference model.
    for (int t = 0; t < 24; t++) begin
      case ($urandom_range(0, 3))
        0: begin a = {$urandom, $urandom}; b = {$urandom, $urandom}; end
        1: begin a = 64'($urandom_range(0, 255)); b = 64'($urandom_range(0, 255)); end
        2: begin a = 64'h8000_0000_0000_0000; b = {$urandom, $urandom}; end
        default: begin a = {$urandom, $urandom}; b = {32'hFFFF_FFFF, 32'h8000_0000}; end
      endcase
      ctl = 2'($urandom);
      w   = ($urandom_range(0, 3) == 0);
      run_op(a, b, ctl, w, $urandom_range(0, 2), "rand", r, lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
